// File: rtl/lcd_frame_writer.sv
// Character LCD writer (HD44780/KS0066, 8-bit, write-only): one-time init, then
// endless refresh of two 16-character lines from a per-frame snapshot.
module lcd_frame_writer #(
  parameter logic [15:0] PowerOnTime   = 16'd40,
  parameter logic [3:0]  EHigh         = 4'd2,
  parameter logic [15:0] InsWaitTime   = 16'd10,
  parameter logic [15:0] ClearWaitTime = 16'd20,
  parameter logic [15:0] DataWaitTime  = 16'd10,
  parameter logic [31:0] RefreshTime   = 32'd320
) (
  input  logic         mclk,
  input  logic         rst,
  input  logic [127:0] LineA,
  input  logic [127:0] LineB,
  output logic [7:0]   DB,
  output logic         RS,
  output logic         E,
  output logic         RW,
  output logic         init_done,
  output logic         frame_done
);
  localparam logic [2:0] POWER_WAIT = 3'd0;
  localparam logic [2:0] SNAP       = 3'd1;
  localparam logic [2:0] SETUP      = 3'd2;
  localparam logic [2:0] EHI        = 3'd3;
  localparam logic [2:0] HOLD       = 3'd4;
  localparam logic [2:0] WAIT       = 3'd5;
  localparam logic [2:0] REFRESH    = 3'd6;

  logic [2:0]   state_q, state_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [7:0]   db_q, db_d;
  logic         rs_q, rs_d;
  logic         e_q, e_d;
  logic         init_done_q, init_done_d;
  logic         frame_done_q, frame_done_d;
  logic [1:0]   init_idx_q, init_idx_d;
  logic [3:0]   char_idx_q, char_idx_d;
  logic         line_q, line_d;
  logic         is_cmd_q, is_cmd_d;
  logic [127:0] snap_a_q, snap_a_d;
  logic [127:0] snap_b_q, snap_b_d;

  logic [15:0]  wait_len;
  logic [3:0]   char_nxt;
  logic         advance;
  logic         start_byte;
  logic [7:0]   nxt_db;
  logic         nxt_rs;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    db_d         = db_q;
    rs_d         = rs_q;
    e_d          = e_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    init_idx_d   = init_idx_q;
    char_idx_d   = char_idx_q;
    line_d       = line_q;
    is_cmd_d     = is_cmd_q;
    snap_a_d     = snap_a_q;
    snap_b_d     = snap_b_q;
    advance      = 1'b0;
    start_byte   = 1'b0;
    nxt_db       = 8'h00;
    nxt_rs       = 1'b0;
    char_nxt     = char_idx_q + 4'd1;

    // The wait after a byte depends on the byte still sitting on the bus.
    if (rs_q)                wait_len = DataWaitTime;
    else if (db_q == 8'h01)  wait_len = ClearWaitTime;
    else                     wait_len = InsWaitTime;

    case (state_q)
      POWER_WAIT: begin
        if (cnt_q == {16'd0, PowerOnTime}) begin
          start_byte = 1'b1;
          nxt_db     = init_byte(2'd0);
          init_idx_d = 2'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      SNAP: begin
        snap_a_d   = LineA;
        snap_b_d   = LineB;
        line_d     = 1'b0;
        is_cmd_d   = 1'b1;
        char_idx_d = 4'd0;
        start_byte = 1'b1;
        nxt_db     = 8'h80;
      end
      SETUP: begin
        state_d = EHI;
        e_d     = 1'b1;
        cnt_d   = 32'd0;
      end
      EHI: begin
        if (cnt_q + 32'd1 >= {28'd0, EHigh}) begin
          state_d = HOLD;
          e_d     = 1'b0;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      HOLD: begin
        if (wait_len == 16'd0) begin
          advance = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = 32'd0;
        end
      end
      WAIT: begin
        if (cnt_q + 32'd1 >= {16'd0, wait_len}) advance = 1'b1;
        else                                   cnt_d   = cnt_q + 32'd1;
      end
      REFRESH: begin
        if (cnt_q + 32'd1 >= RefreshTime) begin
          state_d = SNAP;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = POWER_WAIT;
    endcase

    // Pick the byte that follows the one just finished (or leave the byte loop).
    if (advance) begin
      if (!init_done_q) begin
        if (init_idx_q == 2'd3) begin
          init_done_d = 1'b1;
          state_d     = SNAP;
          cnt_d       = 32'd0;
        end else begin
          init_idx_d = init_idx_q + 2'd1;
          start_byte = 1'b1;
          nxt_db     = init_byte(init_idx_q + 2'd1);
        end
      end else if (is_cmd_q) begin
        is_cmd_d   = 1'b0;
        char_idx_d = 4'd0;
        start_byte = 1'b1;
        nxt_rs     = 1'b1;
        nxt_db     = line_q ? snap_b_q[7:0] : snap_a_q[7:0];
      end else if (char_idx_q == 4'd15) begin
        char_idx_d = char_nxt;
        if (!line_q) begin
          line_d     = 1'b1;
          is_cmd_d   = 1'b1;
          start_byte = 1'b1;
          nxt_db     = 8'hC0;
        end else begin
          state_d      = REFRESH;
          frame_done_d = 1'b1;
          cnt_d        = 32'd0;
        end
      end else begin
        char_idx_d = char_nxt;
        start_byte = 1'b1;
        nxt_rs     = 1'b1;
        nxt_db     = line_q ? snap_b_q[{char_nxt, 3'b000} +: 8]
                            : snap_a_q[{char_nxt, 3'b000} +: 8];
      end
    end

    if (start_byte) begin
      state_d = SETUP;
      db_d    = nxt_db;
      rs_d    = nxt_rs;
      e_d     = 1'b0;
      cnt_d   = 32'd0;
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q      <= POWER_WAIT;
      cnt_q        <= 32'd0;
      db_q         <= 8'h00;
      rs_q         <= 1'b0;
      e_q          <= 1'b0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      init_idx_q   <= 2'd0;
      char_idx_q   <= 4'd0;
      line_q       <= 1'b0;
      is_cmd_q     <= 1'b0;
      snap_a_q     <= {16{8'h20}};
      snap_b_q     <= {16{8'h20}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      db_q         <= db_d;
      rs_q         <= rs_d;
      e_q          <= e_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
      init_idx_q   <= init_idx_d;
      char_idx_q   <= char_idx_d;
      line_q       <= line_d;
      is_cmd_q     <= is_cmd_d;
      snap_a_q     <= snap_a_d;
      snap_b_q     <= snap_b_d;
    end
  end

  assign DB         = db_q;
  assign RS         = rs_q;
  assign E          = e_q;
  assign RW         = 1'b0;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_lcd_frame_writer.sv
// Bench for lcd_frame_writer: bytes captured at each E rise are matched against a
// queue of expected {RS,DB} values with the cycle gap expected since the previous byte.
module tb_lcd_frame_writer;
  localparam logic [15:0] PowerOnTime   = 16'd4;
  localparam logic [3:0]  EHigh         = 4'd2;
  localparam logic [15:0] InsWaitTime   = 16'd3;
  localparam logic [15:0] ClearWaitTime = 16'd6;
  localparam logic [15:0] DataWaitTime  = 16'd2;
  localparam logic [31:0] RefreshTime   = 32'd5;

  logic         mclk = 1'b0;
  logic         rst  = 1'b1;
  logic [127:0] line_a;
  logic [127:0] line_b;
  logic [7:0]   DB;
  logic         RS, E, RW, init_done, frame_done;

  lcd_frame_writer #(
    .PowerOnTime(PowerOnTime), .EHigh(EHigh), .InsWaitTime(InsWaitTime),
    .ClearWaitTime(ClearWaitTime), .DataWaitTime(DataWaitTime), .RefreshTime(RefreshTime)
  ) dut (
    .mclk(mclk), .rst(rst), .LineA(line_a), .LineB(line_b),
    .DB(DB), .RS(RS), .E(E), .RW(RW), .init_done(init_done), .frame_done(frame_done)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic [8:0]  rs_db;
    logic [15:0] gap;
  } exp_t;

  typedef struct {
    logic       rst;
    logic [7:0] db;
    logic       rs;
    logic       e;
    logic       idn;
  } vec_t;

  exp_t sb[$];
  exp_t cur_exp;
  vec_t vecs[14];

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int last_rise = -1;
  int fd_cycle = 0;
  int fd_count = 0;
  int fd_len = 0;
  int ehi_len = 0;
  int rise_total = 0;
  logic       fd_pending = 1'b0;
  logic       prev_e = 1'b0, prev_fd = 1'b0, prev_id = 1'b0, prev_rs = 1'b0;
  logic [7:0] prev_db = 8'h00;
  logic [7:0] rise_db = 8'h00;
  logic       rise_rs = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  task automatic pushByte(input logic rs_v, input logic [7:0] db_v, input int gap);
    exp_t x;
    x.rs_db = {rs_v, db_v};
    x.gap   = 16'(gap);
    sb.push_back(x);
  endtask

  task automatic pushInit();
    pushByte(1'b0, 8'h38, 0);
    pushByte(1'b0, 8'h0C, 7);
    pushByte(1'b0, 8'h01, 7);
    pushByte(1'b0, 8'h06, 10);
  endtask

  task automatic pushFrame(input logic [127:0] a, input logic [127:0] b, input int first_gap);
    pushByte(1'b0, 8'h80, first_gap);
    for (int i = 0; i < 16; i++) pushByte(1'b1, a[8*i +: 8], (i == 0) ? 7 : 6);
    pushByte(1'b0, 8'hC0, 6);
    for (int i = 0; i < 16; i++) pushByte(1'b1, b[8*i +: 8], (i == 0) ? 7 : 6);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst;
    @(posedge mclk);
    @(negedge mclk);
    #2;
  endtask

  task automatic waitFrames(input int target, input int budget);
    int n = 0;
    while (fd_count < target && n < budget) begin
      @(negedge mclk); #2; n++;
    end
    checkOutput("frame_done_reached", 32'(fd_count >= target), 32'd1);
  endtask

  task automatic waitRises(input int target, input int budget);
    int n = 0;
    while (rise_total < target && n < budget) begin
      @(negedge mclk); #2; n++;
    end
    checkOutput("e_rise_reached", 32'(rise_total >= target), 32'd1);
  endtask

  // Bus monitor: byte capture, timing gaps, strobe width and pulse widths.
  always @(negedge mclk) begin
    cycle++;
    if (rst) begin
      prev_e = 1'b0; prev_fd = 1'b0; prev_id = 1'b0;
      ehi_len = 0; fd_len = 0; last_rise = -1; fd_pending = 1'b0;
      prev_db = DB; prev_rs = RS;
    end else begin
      checkOutput("rw_low", 32'(RW), 32'd0);
      if (E && !prev_e) begin
        rise_total++;
        ehi_len = 1;
        rise_db = DB;
        rise_rs = RS;
        checkOutput("setup_before_e", 32'({prev_rs, prev_db}), 32'({RS, DB}));
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_byte: got %0h, expected none (cycle %0d)", {RS, DB}, cycle);
        end else begin
          cur_exp = sb.pop_front();
          checkOutput("byte", 32'({RS, DB}), 32'(cur_exp.rs_db));
          if (cur_exp.gap != 16'd0 && last_rise >= 0)
            checkOutput("byte_gap", 32'(cycle - last_rise), 32'(cur_exp.gap));
        end
        if (fd_pending) begin
          checkOutput("refresh_to_setup", 32'(cycle - 1 - fd_cycle), RefreshTime + 32'd1);
          fd_pending = 1'b0;
        end
        last_rise = cycle;
      end else if (E && prev_e) begin
        ehi_len++;
        checkOutput("db_stable_e_high", 32'({RS, DB}), 32'({rise_rs, rise_db}));
      end else if (!E && prev_e) begin
        checkOutput("e_high_width", 32'(ehi_len), 32'(EHigh));
      end
      if (frame_done) fd_len++;
      else if (prev_fd) begin
        checkOutput("frame_done_width", 32'(fd_len), 32'd1);
        fd_len = 0;
      end
      if (frame_done && !prev_fd) begin
        fd_count++;
        fd_cycle   = cycle;
        fd_pending = 1'b1;
        checkOutput("frame_done_delay", 32'(cycle - last_rise), 32'd5);
      end
      if (init_done && !prev_id) checkOutput("init_done_delay", 32'(cycle - last_rise), 32'd6);
      if (!init_done && prev_id) checkOutput("init_done_sticky", 32'(init_done), 32'd1);
      prev_e = E; prev_fd = frame_done; prev_id = init_done; prev_db = DB; prev_rs = RS;
    end
  end

  initial begin
    repeat (20000) @(posedge mclk);
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    logic [127:0] spaces;
    spaces = {16{8'h20}};
    for (int i = 0; i < 16; i++) line_a[8*i +: 8] = (i < 10) ? 8'(8'h30 + i) : 8'(8'h41 + i - 10);
    line_b = {16{8'h5A}};
    pushInit();
    pushFrame(line_a, line_b, 8);

    // Cycle-by-cycle view of reset, power wait and the first two instructions.
    vecs[0]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 8'h38, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h38, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'h38, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h38, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h38, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 8'h38, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 8'h38, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h0C, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h0C, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), 32'({E, RS, DB, init_done, RW, frame_done}),
                  32'({vecs[i].e, vecs[i].rs, vecs[i].db, vecs[i].idn, 1'b0, 1'b0}));
    end

    waitFrames(1, 1000);
    pushFrame(line_a, line_b, 12);
    base = rise_total;
    waitRises(base + 6, 300);
    line_a = spaces;
    pushFrame(line_a, line_b, 12);
    waitFrames(2, 1000);
    waitFrames(3, 1000);

    // Reset lands while E is high on line-1 character 7.
    pushFrame(line_a, line_b, 12);
    base = rise_total;
    waitRises(base + 9, 300);
    checkOutput("e_high_before_reset", 32'(E), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("reset_async", 32'({E, RS, DB, init_done}), 32'd0);
    sb.delete();
    pushInit();
    pushFrame(line_a, line_b, 8);
    @(posedge mclk); @(negedge mclk); #2;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge mclk); @(negedge mclk); #2;
      checkOutput("power_wait_after_reset", 32'({E, RS, DB, init_done}), 32'd0);
    end
    @(posedge mclk); @(negedge mclk); #2;
    checkOutput("first_ins_after_reset", 32'({E, RS, DB, init_done}), 32'({1'b0, 1'b0, 8'h38, 1'b0}));

    waitFrames(4, 1000);
    repeat (2) @(negedge mclk);
    #2;
    checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
